// File: rtl/serializer_ctrl_pkg.sv
// Shared types and constants for the serializer transmit sequencer.
// Holds the controller state encoding and the shift-register control codes
// so the controller and the datapath agree on one definition.
package serializer_pkg;

    // Controller states; exported on the debug bus as well.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Shift-register control codes.
    localparam logic [1:0] SHR_HOLD = 2'b00;
    localparam logic [1:0] SHR_SHL  = 2'b01;
    localparam logic [1:0] SHR_SHR  = 2'b10;
    localparam logic [1:0] SHR_LOAD = 2'b11;

    // Shift direction for one bit step: MSB-first frames move the register
    // left so the next bit lands in the top position, LSB-first moves right.
    function automatic logic [1:0] shift_code(input logic lsb_first);
        return lsb_first ? SHR_SHR : SHR_SHL;
    endfunction

endpackage

// File: rtl/serializer_ctrl_if.sv
// Producer / serial-line bundle for serializer_ctrl.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends on controller state only, never on
// in_valid. The producer may hold in_valid high across a busy frame; the
// word, lsb_first and clk_div are only looked at in the accepting cycle.
interface serializer_ctrl_if
    import serializer_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             lsb_first;
    logic [DIV_W-1:0] clk_div;
    logic             ser_out;
    logic             ser_en;
    logic             bit_tick;
    logic             done;
    logic             busy;
    state_t           dbg_state;

    // Word producer / line observer side.
    modport master (
        output in_valid,
        output in_data,
        output lsb_first,
        output clk_div,
        input  in_ready,
        input  ser_out,
        input  ser_en,
        input  bit_tick,
        input  done,
        input  busy,
        input  dbg_state
    );

    // Serializer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  lsb_first,
        input  clk_div,
        output in_ready,
        output ser_out,
        output ser_en,
        output bit_tick,
        output done,
        output busy,
        output dbg_state
    );

endinterface

// File: rtl/serializer_ctrl_shift_reg_core.sv
// Universal shift register: hold, shift-left, shift-right, parallel load.
// Shift-left fills bit 0 from d[0]; shift-right fills bit N-1 from d[N-1].
// The controller keeps d at zero except when loading, so shifts fill zeros.
module shift_reg_core
    import serializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    // Register update selected by the control code; clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            case (ctrl)
                SHR_SHL:  r_q <= {r_q[N-2:0], d[0]};
                SHR_SHR:  r_q <= {d[N-1], r_q[N-1:1]};
                SHR_LOAD: r_q <= d;
                default:  r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serializer_ctrl.sv
// Parallel-to-serial transmit sequencer.
// Accepts a word over valid/ready, loads it into the shift register and
// shifts it out one bit per (clk_div+1) clocks, MSB- or LSB-first, then
// pulses done for one cycle. All outputs decode registered state only.
module serializer_ctrl
    import serializer_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serializer_ctrl_if.slave  bus
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    // Controller registers.
    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_clk_div;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_lsb_first;

    // Datapath connections.
    logic             w_accept;
    logic             w_tick;
    logic             w_last_bit;
    logic [1:0]       w_ctrl;
    logic [N-1:0]     w_d;
    logic [N-1:0]     w_q;

    // Acceptance only ever happens in IDLE, so in_ready is a pure state decode.
    assign w_accept   = bus.in_valid && (r_state == IDLE);
    // End of a bit period; comparing before incrementing means an all-ones
    // divider never has to wrap through an overflow.
    assign w_tick     = (r_state == SHIFT) && (r_div_cnt == r_clk_div);
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    // Main FSM with divider and bit counters; config is latched at accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div_cnt   <= '0;
            r_clk_div   <= '0;
            r_bit_cnt   <= '0;
            r_lsb_first <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lsb_first <= bus.lsb_first;
                        r_clk_div   <= bus.clk_div;
                        r_div_cnt   <= '0;
                        r_bit_cnt   <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        if (w_last_bit) begin
                            r_state <= DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Shift-register control: load on accept, step on every non-final tick.
    always_comb begin
        w_ctrl = SHR_HOLD;
        w_d    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ctrl = SHR_LOAD;
                    w_d    = bus.in_data;
                end
            end
            SHIFT: begin
                if (w_tick && !w_last_bit) begin
                    w_ctrl = shift_code(r_lsb_first);
                end
            end
            default: begin
                w_ctrl = SHR_HOLD;
            end
        endcase
    end

    shift_reg_core #(
        .N (N)
    ) u_shift_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (w_ctrl),
        .d     (w_d),
        .q     (w_q)
    );

    // The bit on the line is whichever end of the register the frame leaves from.
    assign bus.ser_out   = (r_state == SHIFT) ? (r_lsb_first ? w_q[0] : w_q[N-1]) : 1'b0;
    assign bus.ser_en    = (r_state == SHIFT);
    assign bus.bit_tick  = w_tick;
    assign bus.done      = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Bench for serializer_ctrl: directed frames with hand-computed line patterns.
// The driver pushes one {bit_tick, ser_out} entry per expected line cycle;
// the monitor pops one entry per cycle in which ser_en is high.
module tb_serializer_ctrl;
    import serializer_pkg::*;

    localparam int N     = 8;
    localparam int DIV_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    bit   mon_en   = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    // clock / reset
    always #5 clk = ~clk;

    serializer_ctrl_if #(.N(N), .DIV_W(DIV_W)) bus ();

    serializer_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pattern[7] is the first bit expected on the line, pattern[0] the last.
    task automatic push_exp(input logic [7:0] pattern, input int div);
        logic b;
        logic t;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c <= div; c++) begin
                b = pattern[7-i];
                t = (c == div);
                exp_q.push_back({t, b});
            end
        end
    endtask

    // Full frame with accept / done / ready-return timing checks.
    task automatic run_frame(input string tag, input logic [7:0] word, input logic lsb,
                             input logic [7:0] div, input logic [7:0] pattern);
        push_exp(pattern, int'(div));
        check({tag, "_ready_idle"}, 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = word;
        bus.lsb_first = lsb;
        bus.clk_div   = div;
        tick();
        // scramble inputs while busy: they must be ignored
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'($urandom_range(0, 255));
        bus.lsb_first = 1'($urandom_range(0, 1));
        bus.clk_div   = 8'($urandom_range(0, 255));
        check({tag, "_ser_en_first"}, 32'(bus.ser_en), 1);
        check({tag, "_busy"}, 32'(bus.busy), 1);
        check({tag, "_ready_busy"}, 32'(bus.in_ready), 0);
        repeat (N * (int'(div) + 1) - 1) tick();
        check({tag, "_ser_en_last"}, 32'(bus.ser_en), 1);
        check({tag, "_done_early"}, 32'(bus.done), 0);
        tick();
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_ser_en_done"}, 32'(bus.ser_en), 0);
        check({tag, "_ready_done"}, 32'(bus.in_ready), 0);
        tick();
        check({tag, "_done_clear"}, 32'(bus.done), 0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
        check({tag, "_busy_clear"}, 32'(bus.busy), 0);
        check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done === 1'b1) n_done++;
            if (bus.ser_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_bit: ser_out %0b with nothing expected at time %0t",
                             bus.ser_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ser_out", 32'(bus.ser_out), 32'(mon_e[0]));
                    check("bit_tick", 32'(bus.bit_tick), 32'(mon_e[1]));
                end
            end else begin
                check("tick_outside_shift", 32'(bus.bit_tick), 0);
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int done_before;
        bus.in_valid  = 1'b1;  // ignored during reset
        bus.in_data   = 8'hFF;
        bus.lsb_first = 1'b0;
        bus.clk_div   = '0;
        rst_n         = 1'b0;
        repeat (3) tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("rst_ser_out", 32'(bus.ser_out), 0);
        check("rst_ser_en", 32'(bus.ser_en), 0);
        check("rst_bit_tick", 32'(bus.bit_tick), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        mon_en = 1'b1;

        // idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", 32'({bus.in_ready, bus.ser_en, bus.bit_tick, bus.done}), 32'b1000);
        end

        run_frame("a5_msb", 8'hA5, 1'b0, 8'd0, 8'b10100101);
        run_frame("c1_lsb", 8'hC1, 1'b1, 8'd0, 8'b10000011);
        run_frame("f0_div2", 8'hF0, 1'b0, 8'd2, 8'b11110000);

        // in_valid held high across two frames; second config changes mid-frame
        push_exp(8'b00010001, 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        bus.lsb_first = 1'b0;
        bus.clk_div   = 8'd0;
        tick();                              // t+1
        bus.in_data = 8'h22;
        bus.clk_div = 8'd5;
        push_exp(8'b00100010, 5);
        repeat (8) tick();                   // t+9
        check("held_done", 32'(bus.done), 1);
        check("held_ready_done", 32'(bus.in_ready), 0);
        tick();                              // t+10
        check("held_ready_back", 32'(bus.in_ready), 1);
        tick();                              // t+11
        bus.in_valid = 1'b0;
        check("held_second_ser_en", 32'(bus.ser_en), 1);
        check("held_second_state", 32'(bus.dbg_state), 32'(SHIFT));
        repeat (47) tick();                  // t+58
        check("held_second_last", 32'(bus.ser_en), 1);
        tick();                              // t+59
        check("held_second_done", 32'(bus.done), 1);
        tick();
        check("held_second_ready", 32'(bus.in_ready), 1);
        check("held_exp_q_empty", 32'(exp_q.size()), 0);

        // reset during bit 4
        done_before = n_done;
        push_exp(8'b01011010, 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.lsb_first = 1'b0;
        bus.clk_div   = 8'd0;
        tick();                              // t+1, bit 0
        bus.in_valid = 1'b0;
        repeat (4) tick();                   // t+5, bit 4
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("midrst_ser_en", 32'(bus.ser_en), 0);
        check("midrst_ser_out", 32'(bus.ser_out), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_done", 32'({bus.done, bus.busy}), 0);
        end
        check("midrst_done_count", 32'(n_done - done_before), 0);
        run_frame("post_rst_3c", 8'h3C, 1'b1, 8'd1, 8'b00111100);

        // reset coinciding with in_valid: no accept
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        rst_n        = 1'b0;
        tick();
        rst_n        = 1'b0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("rst_valid_busy", 32'(bus.busy), 0);
        tick();
        check("rst_valid_still_idle", 32'(bus.dbg_state), 32'(IDLE));

        // all-ones divider: 256 cycles per bit
        run_frame("div_max", 8'h81, 1'b0, 8'hFF, 8'b10000001);

        tick();
        check("final_exp_q_empty", 32'(exp_q.size()), 0);
        check("done_count", 32'(n_done), 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_ctrl.md
Name: serializer_ctrl

Overview:
- Parallel-to-serial transmit sequencer built around a universal shift-register datapath with hold / shift-left / shift-right / load control.
- Accepts a word over a valid/ready handshake, loads it, then shifts it out one bit per programmable bit period, MSB-first or LSB-first.
- Sits between a word producer and a serial line driver.
- Generates every shift-register control code itself; the datapath is never driven externally.

Parameters:
- N, 8, word width; N >= 2.
- DIV_W, 8, width of the bit-period divider.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word
- in_data  in  N  word to serialize
- lsb_first  in  1  0 = MSB-first, 1 = LSB-first; sampled at accept
- clk_div  in  DIV_W  bit period minus 1, in clk cycles; sampled at accept
- ser_out  out  1  serial data
- ser_en  out  1  high while a frame bit is on ser_out
- bit_tick  out  1  pulse on the last cycle of each bit period
- done  out  1  one-cycle pulse after the last bit
- busy  out  1  high when not IDLE

Behaviour:
- Reset: synchronous, active-low, sampled on a clk edge with rst_n = 0.
  - Forces state IDLE and clears the shift register, divider counter, bit counter and latched config.
  - Reset outputs: in_ready = 1 after release, ser_out = 0, ser_en = 0, bit_tick = 0, done = 0, busy = 0.
  - in_valid is ignored during reset.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - Accept = in_valid && in_ready at a clk edge.
  - On accept, the shift register is loaded with in_data (control code LOAD); lsb_first and clk_div are latched; div_cnt = 0; bit_cnt = 0; next state is SHIFT.
  - Without accept, the register holds (code HOLD).
- SHIFT:
  - ser_en = 1.
  - ser_out = q[N-1] if latched lsb_first = 0, else q[0].
  - div_cnt increments each cycle. When div_cnt == latched clk_div: bit_tick = 1 and div_cnt returns to 0.
  - On bit_tick with bit_cnt < N-1: shift (code SHL if MSB-first, SHR if LSB-first), fill bit 0, bit_cnt increments.
  - On bit_tick with bit_cnt == N-1: register holds, next state is DONE.
  - Outside bit_tick cycles: code HOLD.
- DONE: done = 1 for exactly one cycle, in_ready = 0, ser_en = 0, then IDLE.
- Timing:
  - First bit appears on ser_out the cycle after accept.
  - Frame occupies exactly N*(clk_div+1) cycles of ser_en.
  - done follows on the next cycle; in_ready returns the cycle after done.
  - Minimum accept-to-accept spacing is N*(clk_div+1)+2 cycles.
- Outside SHIFT: ser_out = 0, ser_en = 0.
- in_data, lsb_first and clk_div changes while busy: ignored.
- clk_div = 0: one cycle per bit, and bit_tick is high every SHIFT cycle.
- clk_div = all ones: 2^DIV_W cycles per bit; the counter compares without overflow.
- Counter widths: bit_cnt is $clog2(N) bits; div_cnt is DIV_W bits.
- Reset mid-frame: the next cycle is IDLE with outputs at reset values; no done pulse; the partial frame is discarded.
- Reset coinciding with in_valid: no accept.
- busy = (state != IDLE).
- Outputs are combinational decodes of registered state only; no combinational path from inputs to outputs except none at all (in_ready depends on state only).

Decomposition:
- serializer_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - Shift-control constants: SHR_HOLD = 2'b00, SHR_SHL = 2'b01, SHR_SHR = 2'b10, SHR_LOAD = 2'b11.
- Sub-module shift_reg_core:
  - Parameter N; ports clk, rst_n, ctrl[1:0], d[N-1:0], q[N-1:0].
  - Synchronous active-low clear; SHL fills from d[0], SHR fills from d[N-1], LOAD takes d.
  - The controller drives d = in_data on LOAD and d = 0 otherwise.
- Controller FSM, divider counter and bit counter live in serializer_ctrl.

Test Plan:
- N=8, clk_div=0, lsb_first=0, in_data=8'hA5, accept at cycle t:
  - ser_out = 1,0,1,0,0,1,0,1 in cycles t+1..t+8 with ser_en = 1.
  - done = 1 at t+9; in_ready = 1 at t+10.
- lsb_first=1, in_data=8'hC1, clk_div=0:
  - ser_out = 1,0,0,0,0,0,1,1.
  - bit_tick high in all 8 SHIFT cycles.
- clk_div=2, MSB-first, in_data=8'hF0:
  - Each bit held 3 cycles; ser_en high 24 cycles.
  - bit_tick pulses on cycles t+3, t+6, …, t+24.
  - ser_out = 1 for 12 cycles, then 0 for 12 cycles.
- in_valid held high with in_data 8'h11 then 8'h22 (in_data changes and clk_div changes to 5 mid-frame):
  - First frame unaffected.
  - 8'h22 accepted exactly at t+10, with clk_div=5 latched then.
- rst_n = 0 for one cycle during bit 4 of a frame:
  - Next cycle: ser_en = 0, ser_out = 0, busy = 0, in_ready = 1.
  - No done pulse.
  - A new word sends correctly afterwards.
- in_valid = 0 for 20 cycles after reset:
  - in_ready stays 1; ser_en, bit_tick and done all stay 0.
